// File: rtl/pwm_multi_if.sv
// Host-side configuration bundle for pwm_multi: shadowed settings plus the update req/ack pair.
interface pwm_multi_if #(
  parameter int N_CH    = 4,
  parameter int B_WIDTH = 8,
  parameter int B_CLK   = 3
);
  logic [B_CLK-1:0]        sel_clk;
  logic [N_CH*B_WIDTH-1:0] sel_width;
  logic [N_CH*B_WIDTH-1:0] sel_phase;
  logic                    mode;
  logic                    upd_req;
  logic                    upd_ack;

  modport master (output sel_clk, sel_width, sel_phase, mode, upd_req, input upd_ack);
  modport slave  (input sel_clk, sel_width, sel_phase, mode, upd_req, output upd_ack);
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: N_CH PWM channels sharing one prescaler and one edge/center-aligned period counter.
// Define PWM_DEADTIME_EN to add complementary pwm_n outputs with programmable dead time.
//   state    | meaning
//   DIR_UP   | counter rising (the only state used in edge mode)
//   DIR_DOWN | center mode, falling from MAX toward the period end at cnt==1
module pwm_multi #(
  parameter int N_CH    = 4,
  parameter int B_WIDTH = 8,
  parameter int B_CLK   = 3,
  parameter bit PWM_POL = 1'b1
`ifdef PWM_DEADTIME_EN
  ,
  parameter int B_DT    = 4
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            count_en,
  input  logic            s_rst,
  pwm_multi_if.slave      cfg,
`ifdef PWM_DEADTIME_EN
  input  logic [B_DT-1:0] dead_time,
  output logic [N_CH-1:0] pwm_n,
`endif
  output logic [N_CH-1:0] pwm,
  output logic            clk_en,
  output logic            cyc
);
  localparam logic [B_WIDTH-1:0] MAX  = {B_WIDTH{1'b1}};
  localparam logic [B_WIDTH-1:0] ONE  = B_WIDTH'(1);
  localparam logic [N_CH-1:0]    IDLE = {N_CH{PWM_POL}};

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  dir_e                    dir, dir_nxt;
  logic [B_WIDTH-1:0]      cnt, cnt_nxt;
  logic [N_CH*B_WIDTH-1:0] duty_sh, phase_sh;
  logic                    mode_sh;
  logic                    pending;
  logic                    ack_q;
  logic                    last;
  logic                    wrap;
  logic                    load;
  logic [N_CH-1:0]         active;

  generate
    if (B_CLK == 0) begin : g_nopre
      assign clk_en = count_en;
    end else begin : g_pre
      localparam int PW = 2**B_CLK;
      logic [PW-1:0]    pre;
      logic [B_CLK-1:0] sel_clk_sh;
      logic             tap1, tap2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pre        <= '0;
          tap1       <= 1'b0;
          tap2       <= 1'b0;
          sel_clk_sh <= '0;
        end else begin
          if (s_rst) begin
            pre  <= '0;
            tap1 <= 1'b0;
            tap2 <= 1'b0;
          end else begin
            if (count_en) pre <= pre + PW'(1);
            tap1 <= pre[sel_clk_sh];
            tap2 <= tap1;
          end
          if (load) sel_clk_sh <= cfg.sel_clk;
        end
      end

      // rising edge of the selected tap gives one tick per 2**(sel+1) enabled clocks
      assign clk_en = tap1 & ~tap2;
    end
  endgenerate

  assign last        = mode_sh ? (dir == DIR_DOWN && cnt == ONE) : (cnt == MAX);
  assign wrap        = clk_en & last;
  assign load        = wrap & pending & ~s_rst;
  assign cyc         = (cnt == '0) && (dir == DIR_UP);
  assign cfg.upd_ack = ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      phase_sh <= '0;
      mode_sh  <= 1'b0;
      pending  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= load;
      // a request coinciding with the load is absorbed by it
      if (load) begin
        duty_sh  <= cfg.sel_width;
        phase_sh <= cfg.sel_phase;
        mode_sh  <= cfg.mode;
        pending  <= 1'b0;
      end else if (cfg.upd_req) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= DIR_UP;
      cnt <= '0;
    end else begin
      dir <= dir_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (s_rst) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (clk_en) begin
      if (last) begin
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
      end else if (!mode_sh) begin
        cnt_nxt = cnt + ONE;
      end else begin
        case (dir)
          DIR_UP: begin
            if (cnt == MAX) begin
              cnt_nxt = MAX - ONE;
              dir_nxt = DIR_DOWN;
            end else begin
              cnt_nxt = cnt + ONE;
            end
          end
          DIR_DOWN: cnt_nxt = cnt - ONE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_cmp
    logic [B_WIDTH-1:0] duty_i, e_i;
    assign duty_i    = duty_sh[i*B_WIDTH +: B_WIDTH];
    assign e_i       = cnt + phase_sh[i*B_WIDTH +: B_WIDTH];
    assign active[i] = mode_sh ? (cnt < duty_i) : (e_i < duty_i);
  end

`ifdef PWM_DEADTIME_EN
  logic [N_CH-1:0]           act_q, act_d;
  logic [N_CH-1:0]           idle_q, idle_d;
  logic [N_CH-1:0][B_DT-1:0] dt_q, dt_d;
  logic [N_CH-1:0]           pwm_d, pwm_n_d;

  // idle_q keeps both legs quiet until the first compare after a restart
  always_comb begin
    act_d   = act_q;
    idle_d  = idle_q;
    dt_d    = dt_q;
    pwm_d   = IDLE;
    pwm_n_d = IDLE;
    for (int i = 0; i < N_CH; i++) begin
      if (s_rst) begin
        act_d[i]  = 1'b0;
        idle_d[i] = 1'b1;
        dt_d[i]   = '0;
      end else begin
        act_d[i]  = clk_en ? active[i] : act_q[i];
        idle_d[i] = idle_q[i] & ~clk_en;
        if ((act_d[i] != act_q[i]) || (idle_q[i] && clk_en)) begin
          dt_d[i] = dead_time;
        end else if (dt_q[i] != '0) begin
          dt_d[i] = dt_q[i] - B_DT'(1);
        end
      end
      if (!idle_d[i] && dt_d[i] == '0) begin
        pwm_d[i]   = PWM_POL ^ act_d[i];
        pwm_n_d[i] = PWM_POL ^ ~act_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= '0;
      idle_q <= '1;
      dt_q   <= '0;
      pwm    <= IDLE;
      pwm_n  <= IDLE;
    end else begin
      act_q  <= act_d;
      idle_q <= idle_d;
      dt_q   <= dt_d;
      pwm    <= pwm_d;
      pwm_n  <= pwm_n_d;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= IDLE;
    end else if (s_rst) begin
      pwm <= IDLE;
    end else if (clk_en) begin
      pwm <= IDLE ^ active;
    end
  end
`endif
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed scenarios plus randomized reconfiguration, checked against a
// period-position model (position within the period -> counter value -> channel activity).
module tb_pwm_multi;
  localparam int N_CH    = 4;
  localparam int B_WIDTH = 4;
  localparam int B_CLK   = 2;
  localparam bit PWM_POL = 1'b1;
  localparam int MAXV    = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            count_en = 1'b0;
  logic            s_rst = 1'b0;
  logic [N_CH-1:0] pwm;
  logic            clk_en;
  logic            cyc;

  pwm_multi_if #(.N_CH(N_CH), .B_WIDTH(B_WIDTH), .B_CLK(B_CLK)) bus ();

  pwm_multi #(.N_CH(N_CH), .B_WIDTH(B_WIDTH), .B_CLK(B_CLK), .PWM_POL(PWM_POL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (count_en),
    .s_rst    (s_rst),
    .cfg      (bus),
    .pwm      (pwm),
    .clk_en   (clk_en),
    .cyc      (cyc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // host-side requested configuration
  int h_duty[N_CH];
  int h_phase[N_CH];
  int h_mode, h_sel;

  // reference model
  int duty_m[N_CH];
  int phase_m[N_CH];
  int mode_m, sel_m, pend_m, pos_m, skip_iv, clks_since;
  logic [N_CH-1:0] exp_pwm;
  logic exp_ack;

  function automatic int period(input int m);
    return m ? 2*MAXV : MAXV+1;
  endfunction

  function automatic int cnt_at(input int m, input int p);
    if (m != 0 && p > MAXV) return 2*MAXV - p;
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      duty_m[i]  = 0;
      phase_m[i] = 0;
    end
    mode_m = 0; sel_m = 0; pend_m = 0; pos_m = 0;
    skip_iv = 1; clks_since = 0;
    exp_pwm = '1; exp_ack = 1'b0;
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N_CH; i++) begin
      bus.sel_width[i*B_WIDTH +: B_WIDTH] = 4'(h_duty[i]);
      bus.sel_phase[i*B_WIDTH +: B_WIDTH] = 4'(h_phase[i]);
    end
    bus.mode    = 1'(h_mode);
    bus.sel_clk = 2'(h_sel);
  endtask

  // one clock: advance the model with the inputs presented now, then compare at the next negedge
  task automatic cycle();
    logic tick;
    int c, e, act;
    tick = clk_en;
    if (s_rst) begin
      pos_m = 0;
      exp_pwm = '1;
      exp_ack = 1'b0;
      if (bus.upd_req) pend_m = 1;
      if (skip_iv < 1) skip_iv = 1;
      clks_since = 0;
    end else begin
      exp_ack = 1'b0;
      if (tick) begin
        if (skip_iv > 0) skip_iv--;
        else check("tick_period", clks_since, 1 << (sel_m + 1));
        clks_since = 0;
        c = cnt_at(mode_m, pos_m);
        for (int i = 0; i < N_CH; i++) begin
          e = (c + phase_m[i]) % (MAXV + 1);
          act = mode_m ? (c < duty_m[i]) : (e < duty_m[i]);
          exp_pwm[i] = PWM_POL ^ act[0];
        end
        if (pos_m == period(mode_m) - 1) begin
          pos_m = 0;
          if (pend_m != 0) begin
            if (h_sel != sel_m) skip_iv = 2;
            for (int i = 0; i < N_CH; i++) begin
              duty_m[i]  = h_duty[i];
              phase_m[i] = h_phase[i];
            end
            mode_m = h_mode; sel_m = h_sel;
            pend_m = 0;
            exp_ack = 1'b1;
          end else if (bus.upd_req) pend_m = 1;
        end else begin
          pos_m++;
          if (bus.upd_req) pend_m = 1;
        end
      end else if (bus.upd_req) pend_m = 1;
      clks_since++;
    end
    @(negedge clk);
    check("pwm", pwm, exp_pwm);
    check("upd_ack", bus.upd_ack, exp_ack);
    check("cyc", cyc, pos_m == 0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic request();
    drive_bus();
    bus.upd_req = 1'b1;
    cycle();
    bus.upd_req = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    while (!exp_ack && n < budget) begin
      cycle();
      n++;
    end
    if (!exp_ack) check("ack_timeout", 0, 1);
  endtask

  task automatic wait_pos(input int p, input int budget);
    int n;
    n = 0;
    while (pos_m != p && n < budget) begin
      cycle();
      n++;
    end
  endtask

  task automatic pulse_srst();
    s_rst = 1'b1;
    cycle();
    s_rst = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("arst_pwm", pwm, 4'hF);
    check("arst_ack", bus.upd_ack, 0);
    check("arst_cyc", cyc, 1);
    check("arst_clk_en", clk_en, 0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.upd_req = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      h_duty[i] = 0;
      h_phase[i] = 0;
    end
    h_mode = 0; h_sel = 0;
    drive_bus();
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm, 4'hF);
    check("rst_ack", bus.upd_ack, 0);
    check("rst_cyc", cyc, 1);
    check("rst_clk_en", clk_en, 0);
    rst_n = 1'b1;

    // idle with the prescaler disabled
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("idle_clk_en", clk_en, 0);
    end

    // tick every 4 clks, edge mode, ch0 duty 4 phase 0, ch1 duty 4 phase 8
    h_sel = 1; h_mode = 0;
    h_duty[0] = 4; h_phase[0] = 0;
    h_duty[1] = 4; h_phase[1] = 8;
    count_en = 1'b1;
    request();
    wait_ack(400);
    run(140);

    // mid-period update of ch0 duty to 10
    wait_pos(5, 200);
    h_duty[0] = 10;
    request();
    wait_ack(400);
    run(140);

    // center mode, ch0 duty 3
    h_mode = 1; h_duty[0] = 3;
    request();
    wait_ack(400);
    run(260);

    // s_rst while a request is pending
    wait_pos(2, 400);
    h_mode = 0; h_duty[0] = 6;
    request();
    wait_pos(7, 400);
    pulse_srst();
    wait_ack(600);
    run(80);

    for (int it = 0; it < 14; it++) begin
      int r;
      h_sel  = $urandom_range(0, 1);
      h_mode = $urandom_range(0, 1);
      for (int i = 0; i < N_CH; i++) begin
        r = $urandom_range(0, 5);
        h_duty[i]  = (r == 0) ? 0 : (r == 1) ? MAXV : $urandom_range(0, MAXV);
        h_phase[i] = $urandom_range(0, MAXV);
      end
      run($urandom_range(0, 40));
      request();
      wait_ack(3000);
      run($urandom_range(20, 200));
      if (it % 5 == 2) begin
        pulse_srst();
        run($urandom_range(10, 60));
      end
      if (it == 7) begin
        async_reset();
        run(40);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
